// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline control bus: ctrl_t, stage indices and the
// pipeline_ctrl state encoding.
package pipeline_types;

    localparam int NUM_STAGES = 8;

    localparam int STAGE_PC       = 0;
    localparam int STAGE_IF1      = 1;
    localparam int STAGE_IF2      = 2;
    localparam int STAGE_ID       = 3;
    localparam int STAGE_DISPATCH = 4;
    localparam int STAGE_EX       = 5;
    localparam int STAGE_MEM      = 6;
    localparam int STAGE_WB       = 7;

    typedef struct packed {
        logic [NUM_STAGES-1:0] pause;
        logic                  exception_flush;
    } ctrl_t;

    typedef enum logic [1:0] {
        PCTRL_RUN   = 2'd0,
        PCTRL_FLUSH = 2'd1,
        PCTRL_IDLE  = 2'd2
    } pctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_pause_encoder.sv
// Highest-set-bit thermometer: every stage at or behind the most downstream
// stall request is paused.
module pause_encoder #(
    parameter int STAGES = 8
) (
    input  logic [STAGES-1:0] pause_req,
    output logic [STAGES-1:0] pause_therm
);

    logic acc;

    always_comb begin
        pause_therm = '0;
        acc         = 1'b0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            acc            = acc | pause_req[i];
            pause_therm[i] = acc;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline control unit: stall merging, exception flush/redirect, idle parking
// and a saturating stall-cycle counter.
//
// state | meaning
// RUN   | normal operation, pause follows the stall requests
// FLUSH | cycle after a flush, redirect strobe to the pc stage
// IDLE  | idle committed, front of pipe parked until an interrupt is pending
module pipeline_ctrl
    import pipeline_types::*;
#(
    parameter int                STAGES    = 8,
    parameter logic [STAGES-1:0] IDLE_MASK = 8'h7F
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STAGES-1:0] pause_req,
    input  logic              exc_valid,
    input  logic [31:0]       exc_target_pc,
    input  logic              idle_commit,
    input  logic              intr_pending,
    output ctrl_t             ctrl,
    output logic              flush_pc_valid,
    output logic [31:0]       flush_pc,
    output logic [31:0]       stall_cnt
);

    pctrl_state_t      state_q, state_d;
    logic              flush_pc_valid_q, flush_pc_valid_d;
    logic [31:0]       flush_pc_q, flush_pc_d;
    logic [31:0]       stall_cnt_q, stall_cnt_d;
    logic [STAGES-1:0] pause_therm;
    logic [STAGES-1:0] pause;
    logic              exception_flush;

    pause_encoder #(.STAGES(STAGES)) u_pause_encoder (
        .pause_req   (pause_req),
        .pause_therm (pause_therm)
    );

    always_comb begin
        state_d          = state_q;
        pause            = pause_therm;
        exception_flush  = 1'b0;
        flush_pc_valid_d = 1'b0;
        flush_pc_d       = flush_pc_q;
        case (state_q)
            PCTRL_RUN: begin
                if (exc_valid) begin
                    exception_flush  = 1'b1;
                    pause            = '0;
                    flush_pc_valid_d = 1'b1;
                    flush_pc_d       = exc_target_pc;
                    state_d          = PCTRL_FLUSH;
                end else if (idle_commit) begin
                    state_d = PCTRL_IDLE;
                end
            end
            PCTRL_FLUSH: begin
                // pc stage must be free to load the redirect target this cycle
                pause[STAGE_PC] = 1'b0;
                state_d         = PCTRL_RUN;
            end
            PCTRL_IDLE: begin
                pause = IDLE_MASK | pause_therm;
                if (exc_valid) begin
                    exception_flush  = 1'b1;
                    pause            = '0;
                    flush_pc_valid_d = 1'b1;
                    flush_pc_d       = exc_target_pc;
                    state_d          = PCTRL_FLUSH;
                end else if (intr_pending) begin
                    state_d = PCTRL_RUN;
                end
            end
            default: state_d = PCTRL_RUN;
        endcase

        stall_cnt_d = stall_cnt_q;
        if ((|pause) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= PCTRL_RUN;
            flush_pc_valid_q <= 1'b0;
            flush_pc_q       <= 32'd0;
            stall_cnt_q      <= 32'd0;
        end else begin
            state_q          <= state_d;
            flush_pc_valid_q <= flush_pc_valid_d;
            flush_pc_q       <= flush_pc_d;
            stall_cnt_q      <= stall_cnt_d;
        end
    end

    assign ctrl.pause           = pause;
    assign ctrl.exception_flush = exception_flush;
    assign flush_pc_valid       = flush_pc_valid_q;
    assign flush_pc             = flush_pc_q;
    assign stall_cnt            = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: reset, thermometer, flush/redirect, idle,
// simultaneous events and stall counter saturation.
module tb_pipeline_ctrl;
    import pipeline_types::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  pause_req;
    logic        exc_valid;
    logic [31:0] exc_target_pc;
    logic        idle_commit;
    logic        intr_pending;
    ctrl_t       ctrl;
    logic        flush_pc_valid;
    logic [31:0] flush_pc;
    logic [31:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .pause_req      (pause_req),
        .exc_valid      (exc_valid),
        .exc_target_pc  (exc_target_pc),
        .idle_commit    (idle_commit),
        .intr_pending   (intr_pending),
        .ctrl           (ctrl),
        .flush_pc_valid (flush_pc_valid),
        .flush_pc       (flush_pc),
        .stall_cnt      (stall_cnt)
    );

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        pause_req     = 8'h00;
        exc_valid     = 1'b0;
        exc_target_pc = 32'd0;
        idle_commit   = 1'b0;
        intr_pending  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (ctrl.pause !== 8'h00) begin errors++; $display("FAIL reset_pause got=%h exp=00", ctrl.pause); end
        checks++; if (ctrl.exception_flush !== 1'b0) begin errors++; $display("FAIL reset_flush got=%b exp=0", ctrl.exception_flush); end
        checks++; if (flush_pc_valid !== 1'b0) begin errors++; $display("FAIL reset_fpv got=%b exp=0", flush_pc_valid); end
        checks++; if (flush_pc !== 32'd0) begin errors++; $display("FAIL reset_fpc got=%h exp=0", flush_pc); end
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
    endtask

    task automatic test_thermometer();
        logic [7:0] req_v [6] = '{8'h20, 8'h11, 8'h80, 8'h00, 8'h01, 8'h48};
        logic [7:0] exp_v [6] = '{8'h3F, 8'h1F, 8'hFF, 8'h00, 8'h01, 8'h7F};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            pause_req = req_v[i];
            #1;
            checks++;
            if (ctrl.pause !== exp_v[i]) begin
                errors++;
                $display("FAIL therm req=%h got=%h exp=%h", req_v[i], ctrl.pause, exp_v[i]);
            end
        end
    endtask

    task automatic test_exception();
        do_reset();
        @(negedge clk);
        exc_valid = 1'b1; exc_target_pc = 32'h1C00_8000; pause_req = 8'hFF;
        #1;
        checks++; if (ctrl.exception_flush !== 1'b1) begin errors++; $display("FAIL exc_flush_n got=%b exp=1", ctrl.exception_flush); end
        checks++; if (ctrl.pause !== 8'h00) begin errors++; $display("FAIL exc_pause_n got=%h exp=00", ctrl.pause); end
        checks++; if (flush_pc_valid !== 1'b0) begin errors++; $display("FAIL exc_fpv_n got=%b exp=0", flush_pc_valid); end
        @(negedge clk);
        exc_target_pc = 32'hDEAD_0000;
        #1;
        checks++; if (flush_pc_valid !== 1'b1) begin errors++; $display("FAIL exc_fpv_n1 got=%b exp=1", flush_pc_valid); end
        checks++; if (flush_pc !== 32'h1C00_8000) begin errors++; $display("FAIL exc_fpc_n1 got=%h exp=1c008000", flush_pc); end
        checks++; if (ctrl.exception_flush !== 1'b0) begin errors++; $display("FAIL exc_flush_n1 got=%b exp=0", ctrl.exception_flush); end
        checks++; if (ctrl.pause !== 8'hFE) begin errors++; $display("FAIL exc_pause_n1 got=%h exp=fe", ctrl.pause); end
        @(negedge clk);
        exc_valid = 1'b0; pause_req = 8'h00;
        #1;
        checks++; if (flush_pc_valid !== 1'b0) begin errors++; $display("FAIL exc_fpv_n2 got=%b exp=0", flush_pc_valid); end
        checks++; if (flush_pc !== 32'h1C00_8000) begin errors++; $display("FAIL exc_fpc_n2 got=%h exp=1c008000", flush_pc); end
        checks++; if (stall_cnt !== 32'd1) begin errors++; $display("FAIL exc_cnt got=%0d exp=1", stall_cnt); end
    endtask

    task automatic test_idle();
        logic [7:0] exp_p;
        do_reset();
        @(negedge clk);
        idle_commit = 1'b1;
        #1;
        checks++; if (ctrl.pause !== 8'h00) begin errors++; $display("FAIL idle_pause_n got=%h exp=00", ctrl.pause); end
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            idle_commit  = 1'b0;
            pause_req    = (i == 2) ? 8'h80 : 8'h00;
            intr_pending = (i == 5);
            exp_p        = (i == 2) ? 8'hFF : 8'h7F;
            #1;
            checks++;
            if (ctrl.pause !== exp_p) begin
                errors++;
                $display("FAIL idle_pause_n%0d got=%h exp=%h", i, ctrl.pause, exp_p);
            end
        end
        @(negedge clk);
        intr_pending = 1'b0;
        #1;
        checks++; if (ctrl.pause !== 8'h00) begin errors++; $display("FAIL idle_exit got=%h exp=00", ctrl.pause); end
        @(negedge clk);
        pause_req = 8'h04;
        #1;
        checks++; if (ctrl.pause !== 8'h07) begin errors++; $display("FAIL idle_after got=%h exp=07", ctrl.pause); end
    endtask

    task automatic test_exc_idle_same();
        do_reset();
        @(negedge clk);
        exc_valid = 1'b1; idle_commit = 1'b1; exc_target_pc = 32'h0000_1000;
        #1;
        checks++; if (ctrl.exception_flush !== 1'b1) begin errors++; $display("FAIL same_flush got=%b exp=1", ctrl.exception_flush); end
        @(negedge clk);
        exc_valid = 1'b0; idle_commit = 1'b0;
        #1;
        checks++; if (flush_pc_valid !== 1'b1) begin errors++; $display("FAIL same_fpv got=%b exp=1", flush_pc_valid); end
        checks++; if (flush_pc !== 32'h0000_1000) begin errors++; $display("FAIL same_fpc got=%h exp=00001000", flush_pc); end
        checks++; if (ctrl.pause !== 8'h00) begin errors++; $display("FAIL same_pause_n1 got=%h exp=00", ctrl.pause); end
        @(negedge clk);
        #1;
        checks++; if (ctrl.pause !== 8'h00) begin errors++; $display("FAIL same_pause_n2 got=%h exp=00", ctrl.pause); end
    endtask

    task automatic test_exc_in_idle();
        do_reset();
        @(negedge clk);
        idle_commit = 1'b1;
        @(negedge clk);
        idle_commit = 1'b0;
        #1;
        checks++; if (ctrl.pause !== 8'h7F) begin errors++; $display("FAIL ie_pause_idle got=%h exp=7f", ctrl.pause); end
        @(negedge clk);
        exc_valid = 1'b1; intr_pending = 1'b1; exc_target_pc = 32'h2000_0040;
        #1;
        checks++; if (ctrl.exception_flush !== 1'b1) begin errors++; $display("FAIL ie_flush got=%b exp=1", ctrl.exception_flush); end
        checks++; if (ctrl.pause !== 8'h00) begin errors++; $display("FAIL ie_pause_flush got=%h exp=00", ctrl.pause); end
        @(negedge clk);
        exc_valid = 1'b0; intr_pending = 1'b0;
        #1;
        checks++; if (flush_pc_valid !== 1'b1) begin errors++; $display("FAIL ie_fpv got=%b exp=1", flush_pc_valid); end
        checks++; if (flush_pc !== 32'h2000_0040) begin errors++; $display("FAIL ie_fpc got=%h exp=20000040", flush_pc); end
        @(negedge clk);
        #1;
        checks++; if (ctrl.pause !== 8'h00) begin errors++; $display("FAIL ie_pause_run got=%h exp=00", ctrl.pause); end
        checks++; if (flush_pc_valid !== 1'b0) begin errors++; $display("FAIL ie_fpv_end got=%b exp=0", flush_pc_valid); end
    endtask

    task automatic test_stall_cnt();
        do_reset();
        pause_req = 8'h08;
        repeat (10) @(negedge clk);
        pause_req = 8'h00;
        #1;
        checks++; if (stall_cnt !== 32'd10) begin errors++; $display("FAIL cnt_10 got=%0d exp=10", stall_cnt); end
        @(negedge clk);
        #1;
        checks++; if (stall_cnt !== 32'd10) begin errors++; $display("FAIL cnt_hold got=%0d exp=10", stall_cnt); end
    endtask

    task automatic test_saturate();
        @(negedge clk);
        pause_req = 8'h00;
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        #1;
        checks++; if (stall_cnt !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sat_preload got=%h exp=fffffffe", stall_cnt); end
        pause_req = 8'h08;
        @(negedge clk);
        #1;
        checks++; if (stall_cnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_1 got=%h exp=ffffffff", stall_cnt); end
        repeat (2) @(negedge clk);
        pause_req = 8'h00;
        #1;
        checks++; if (stall_cnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_3 got=%h exp=ffffffff", stall_cnt); end
    endtask

    initial begin
        rst           = 1'b1;
        pause_req     = 8'h00;
        exc_valid     = 1'b0;
        exc_target_pc = 32'd0;
        idle_commit   = 1'b0;
        intr_pending  = 1'b0;
        test_reset();
        test_thermometer();
        test_exception();
        test_idle();
        test_exc_idle_same();
        test_exc_in_idle();
        test_stall_cnt();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central pipeline control unit and the producer side of the `ctrl_t` bus consumed by every inter-stage pipeline register, for example `if_id` and the dispatch-to-execute register. It merges per-stage stall requests into a monotonic pause vector and turns committed exceptions and `ertn` into a one-cycle pipeline flush followed by a registered PC redirect. It also parks the front of the pipeline while an `idle` instruction waits for an interrupt, and keeps a saturating stall-cycle counter for performance monitoring.

## Interface
- `STAGES`, default 8: pause vector width. Stage indices: 0 pc, 1 if1, 2 if2, 3 id, 4 dispatch, 5 ex, 6 mem, 7 wb.
- `IDLE_MASK`, default 8'h7F: pause bits forced high in the IDLE state. wb stays free so the interrupt can commit.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `pause_req`  in  STAGES  per-stage stall request; bit i set means stage i cannot advance this cycle.
- `exc_valid`  in  1  commit stage raises an exception, interrupt or `ertn` this cycle.
- `exc_target_pc`  in  32  redirect address; valid with `exc_valid`.
- `idle_commit`  in  1  an `idle` instruction commits this cycle.
- `intr_pending`  in  1  any enabled interrupt is pending (level).
- `ctrl`  out  ctrl_t  fields `pause[STAGES-1:0]` and `exception_flush`.
- `flush_pc_valid`  out  1  one-cycle redirect strobe to the pc stage.
- `flush_pc`  out  32  redirect target.
- `stall_cnt`  out  32  number of cycles with any `pause` bit set; saturates.

## Operation
- Pause encoding, combinational:
  - k = highest set index in `pause_req`.
  - `pause[k:0]` = 1 and all higher bits = 0 (thermometer). This keeps every register behind a stalled stage frozen and lets the register just ahead of it insert a bubble.
  - `pause_req` = 0 gives `pause` = 0.
- States: RUN, FLUSH, IDLE.
- RUN:
  - `pause` = thermometer(`pause_req`).
  - `exc_valid`: `exception_flush` = 1 combinationally and `pause` = 0 in the same cycle; capture `exc_target_pc`; next state FLUSH.
  - Otherwise `idle_commit`: next state IDLE.
  - `exc_valid` has priority over `idle_commit` in the same cycle.
- FLUSH (always exactly one cycle):
  - `flush_pc_valid` = 1 and `flush_pc` = captured target.
  - `pause[0]` forced 0; all other bits come from thermometer(`pause_req`).
  - `exc_valid` is ignored, since the pipeline was just emptied.
  - Next state RUN.
- IDLE:
  - `pause` = `IDLE_MASK` OR thermometer(`pause_req`).
  - `intr_pending` = 1: next state RUN. The interrupt is later delivered through `exc_valid` from commit.
  - `exc_valid` in IDLE: handled exactly as in RUN (flush, then FLUSH). It has priority over `intr_pending`.
- `exception_flush` is 0 in every state except when RUN or IDLE sees `exc_valid`.
- `stall_cnt`:
  - Increments at each posedge where the cycle's `pause` != 0.
  - Holds at 32'hFFFF_FFFF.
  - Flush cycles are not counted (their `pause` is 0).
- Reset: state RUN; `flush_pc_valid` 0; `flush_pc` 0; `stall_cnt` 0. `ctrl` then follows its combinational rules with state RUN.

## Timing
- `pause` and `exception_flush`: zero-latency combinational from inputs and current state. There is no register between `pause_req` and `pause`.
- Redirect: `exc_valid` in cycle N produces `exception_flush` in N (all pipe registers clear at the end of N). `flush_pc_valid` is high in N+1 only, and the pc stage loads `flush_pc` at the end of N+1.
- Back-to-back `exc_valid` in N and N+1: the N+1 request is dropped.
- IDLE:
  - Entered at the end of the `idle_commit` cycle; the first pause cycle is N+1.
  - Exit: `intr_pending` sampled in cycle M releases `pause` in M+1.
- `rst` asserted mid-FLUSH or mid-IDLE: next cycle is RUN with `flush_pc_valid` 0 and the counter cleared.
- `flush_pc_valid`, `flush_pc` and `stall_cnt` are registered outputs.

## Structure
- `pipeline_types` package:
  - `ctrl_t` (pause vector plus `exception_flush`).
  - Stage index constants `STAGE_PC` … `STAGE_WB`.
  - State enum `pctrl_state_t`.
- One sub-module, `pause_encoder`: purely combinational highest-set-bit thermometer, `STAGES` wide, reused by the redirect/idle logic.
- Top level holds the state register, target capture, redirect strobe and counter.

## Test plan
- Reset for 2 cycles with all inputs 0: `pause` = 8'h00, `exception_flush` = 0, `flush_pc_valid` = 0, `stall_cnt` = 0.
- Thermometer encoding:
  - `pause_req` = 8'h20 gives `pause` = 8'h3F.
  - 8'h11 gives 8'h1F.
  - 8'h80 gives 8'hFF.
  - 8'h00 gives 8'h00.
- Exception with stall:
  - `exc_valid` = 1, `exc_target_pc` = 32'h1C00_8000, `pause_req` = 8'hFF in cycle N: `exception_flush` = 1 and `pause` = 0 in N.
  - N+1: `flush_pc_valid` = 1, `flush_pc` = 32'h1C00_8000, `exception_flush` = 0 despite `exc_valid` = 1.
  - N+2: `flush_pc_valid` = 0.
- Idle entry and exit:
  - `idle_commit` in N: `pause` = 8'h7F from N+1.
  - `intr_pending` = 1 in N+5: `pause` = 8'h00 in N+6.
- Simultaneous events:
  - `exc_valid` and `idle_commit` in the same cycle: flush, state FLUSH, no IDLE pause afterwards.
  - `exc_valid` during IDLE: flush in that cycle, redirect on the next.
- Stall counter:
  - `pause_req[3]` = 1 for 10 cycles from reset: `stall_cnt` = 10.
  - Preload `stall_cnt` = 32'hFFFF_FFFE by force, then stall 3 cycles: counter ends at 32'hFFFF_FFFF.
